// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter of fetch (m0, read-only) and load/store (m1) masters onto a single-port RAM with LAT-cycle reads
module mem_arbiter #(
  parameter int AW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_we,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_wstrb,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic [31:0]   mem_rdata
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t     state_q;
  logic [2:0] cnt_q;
  logic       owner_q, last_q, idle, rd;
  assign idle      = rstn && state_q == IDLE;
  assign m1_gnt    = idle && m1_req && (!m0_req || !last_q);
  assign m0_gnt    = idle && m0_req && !m1_gnt;
  assign mem_en    = m0_gnt || m1_gnt;
  assign mem_we    = m1_gnt && m1_we;
  assign mem_addr  = m1_gnt ? m1_addr : m0_gnt ? m0_addr : '0;
  assign mem_wdata = m1_gnt ? m1_wdata : '0;
  assign mem_wstrb = m1_gnt ? m1_wstrb : '0;
  assign rd        = mem_en && !mem_we;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      last_q    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      if (mem_en) last_q <= m1_gnt;
      if (state_q == IDLE) begin
        if (rd) begin
          state_q <= WAIT;
          cnt_q   <= 3'(LAT);
          owner_q <= m1_gnt;
        end
      end else begin
        cnt_q <= cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_q <= IDLE;
          if (owner_q) begin
            m1_rdata  <= mem_rdata;
            m1_rvalid <= 1'b1;
          end else begin
            m0_rdata  <= mem_rdata;
            m0_rvalid <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter (LAT=1 and LAT=3 instances)
module tb_mem_arbiter;
  localparam int AW = 32;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic m0_req = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m1_wdata = '0;
  logic [3:0] m1_wstrb = '0;
  logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_en, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [3:0] mem_wstrb;
  logic b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_en, b_mem_we;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_wdata, b_mem_rdata;
  logic [AW-1:0] b_mem_addr;
  logic [3:0] b_mem_wstrb;
  logic [31:0] p1, bq1, bq2, bq3;
  logic [31:0] junk = 32'h0;
  bit [31:0] ram [256];
  bit wr [256];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .LAT(1)) u_a (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.AW(AW), .LAT(3)) u_b (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wstrb(b_mem_wstrb), .mem_rdata(b_mem_rdata)
  );

  function automatic logic [31:0] rd(input logic [31:0] a);
    return wr[a[9:2]] ? ram[a[9:2]] : {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) o[8*i +: 8] = w[8*i +: 8];
    return o;
  endfunction

  // RAM models: instance a sees a real RAM with LAT=1, instance b a fixed pattern with LAT=3;
  // cycles without a read return junk so a mistimed capture shows up
  always @(posedge clk) begin
    junk <= junk + 32'h1357_9BDF;
    p1   <= (mem_en && !mem_we) ? rd(mem_addr) : 32'hBAD0_0000 ^ junk;
    bq1  <= (b_mem_en && !b_mem_we) ? b_mem_addr ^ 32'h3333_3333 : 32'h0BAD_0000 ^ junk;
    bq2  <= bq1;
    bq3  <= bq2;
    if (mem_en && mem_we) begin
      ram[mem_addr[9:2]] <= merge(rd(mem_addr), mem_wdata, mem_wstrb);
      wr[mem_addr[9:2]]  <= 1'b1;
    end
  end
  assign mem_rdata   = p1;
  assign b_mem_rdata = bq3;

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h100; m1_addr = 32'h200; m1_we = 1'b0;
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb});
    end
    total++;
    if ({m0_rdata, m1_rdata} !== 64'h0) begin
      bad++; $display("FAIL reset_rdata got=%h exp=0", {m0_rdata, m1_rdata});
    end
    total++;
    if ({b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata, b_mem_wstrb, b_m0_rdata, b_m1_rdata} !== '0) begin
      bad++; $display("FAIL reset_lat3 got=%h exp=0", {b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_mem_en, b_mem_we, b_mem_addr});
    end
    nxt;
  endtask

  task automatic test_first_grant;
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt, mem_en, mem_we, mem_addr} !== {4'b0110, 32'h200}) begin
      bad++; $display("FAIL contend_first got=%h exp=%h", {m0_gnt, m1_gnt, mem_en, mem_we, mem_addr}, {4'b0110, 32'h200});
    end
    nxt; m1_req = 1'b0;
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt, mem_en, m1_rvalid} !== 4'b0) begin
      bad++; $display("FAIL contend_wait got=%b exp=0000", {m0_gnt, m1_gnt, mem_en, m1_rvalid});
    end
    nxt;
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt, m1_rvalid, m1_rdata, mem_addr} !== {3'b101, rd(32'h200), 32'h100}) begin
      bad++; $display("FAIL contend_second got=%h exp=%h", {m0_gnt, m1_gnt, m1_rvalid, m1_rdata, mem_addr}, {3'b101, rd(32'h200), 32'h100});
    end
    nxt; m0_req = 1'b0;
    @(negedge clk);
    total++;
    if (m0_rvalid !== 1'b0) begin
      bad++; $display("FAIL contend_m0_early got=%b exp=0", m0_rvalid);
    end
    nxt;
    @(negedge clk);
    total++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, rd(32'h100)}) begin
      bad++; $display("FAIL contend_m0_data got=%h exp=%h", {m0_rvalid, m0_rdata}, {1'b1, rd(32'h100)});
    end
    nxt;
  endtask

  task automatic test_single_read;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h10; m1_wdata = 32'hDEADBEEF; m1_wstrb = 4'hF;
    @(negedge clk);
    total++;
    if ({m1_gnt, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb} !== {3'b111, 32'h10, 32'hDEADBEEF, 4'hF}) begin
      bad++; $display("FAIL preload_write got=%h", {m1_gnt, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb});
    end
    nxt; m1_req = 1'b0; m0_req = 1'b1; m0_addr = 32'h10;
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb} !== {4'b1010, 32'h10, 32'h0, 4'h0}) begin
      bad++; $display("FAIL read_grant got=%h exp=%h", {m0_gnt, m1_gnt, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb}, {4'b1010, 32'h10, 32'h0, 4'h0});
    end
    nxt; m0_req = 1'b0;
    @(negedge clk);
    total++;
    if (m0_rvalid !== 1'b0) begin
      bad++; $display("FAIL read_t1 got=%b exp=0", m0_rvalid);
    end
    nxt;
    @(negedge clk);
    total++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      bad++; $display("FAIL read_t2 got=%h exp=%h", {m0_rvalid, m0_rdata}, {1'b1, 32'hDEADBEEF});
    end
    nxt;
    @(negedge clk);
    total++;
    if ({m0_rvalid, m0_rdata} !== {1'b0, 32'hDEADBEEF}) begin
      bad++; $display("FAIL read_hold got=%h exp=%h", {m0_rvalid, m0_rdata}, {1'b0, 32'hDEADBEEF});
    end
    total++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      bad++; $display("FAIL idle_bus got=%h exp=0", {mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb});
    end
    nxt;
  endtask

  task automatic test_writes;
    logic [31:0] d;
    m1_req = 1'b1; m1_we = 1'b1; m1_wstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      m1_addr = 32'h20 + 32'(4 * i); m1_wdata = d;
      @(negedge clk);
      total++;
      if ({m1_gnt, mem_en, mem_we, mem_addr, mem_wdata, m0_rvalid, m1_rvalid} !== {3'b111, 32'h20 + 32'(4 * i), d, 2'b00}) begin
        bad++; $display("FAIL write_%0d got=%h exp=%h", i, {m1_gnt, mem_en, mem_we, mem_addr, mem_wdata, m0_rvalid, m1_rvalid}, {3'b111, 32'h20 + 32'(4 * i), d, 2'b00});
      end
      nxt;
    end
    m1_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
        bad++; $display("FAIL write_no_rvalid got=%b exp=00", {m0_rvalid, m1_rvalid});
      end
      nxt;
    end
  endtask

  task automatic test_alternate;
    int n = 0;
    logic g0, g1;
    rstn = 1'b0; #1; rstn = 1'b1;
    m0_req = 1'b1; m0_addr = 32'h300; m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h3F0; m1_wdata = $urandom; m1_wstrb = 4'hF;
    for (int c = 0; c < 30 && n < 8; c++) begin
      @(negedge clk);
      g0 = m0_gnt; g1 = m1_gnt;
      if (g0 || g1) begin
        total++;
        if ({g0, g1, mem_we, mem_wstrb, 8'(c)} !== {n[0], !n[0], !n[0], {4{!n[0]}}, 8'((n / 2) * 3 + n % 2)}) begin
          bad++; $display("FAIL alternate_%0d got=%h exp=%h", n, {g0, g1, mem_we, mem_wstrb, 8'(c)}, {n[0], !n[0], !n[0], {4{!n[0]}}, 8'((n / 2) * 3 + n % 2)});
        end
        n++;
      end
      nxt;
      if (g0) m0_addr = 32'(($urandom_range(0, 15)) * 4);
      if (g1) m1_wdata = $urandom;
    end
    total++;
    if (n != 8) begin
      bad++; $display("FAIL alternate_timeout got=%0d grants exp=8", n);
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic test_lat3;
    rstn = 1'b0; #1; rstn = 1'b1;
    m1_req = 1'b0; m0_req = 1'b1; m0_addr = 32'h40;
    @(negedge clk);
    total++;
    if ({b_m0_gnt, b_mem_en, b_mem_addr} !== {2'b11, 32'h40}) begin
      bad++; $display("FAIL lat3_grant got=%h exp=%h", {b_m0_gnt, b_mem_en, b_mem_addr}, {2'b11, 32'h40});
    end
    nxt; m0_req = 1'b0;
    @(negedge clk);
    total++;
    if ({b_m0_gnt, b_m1_gnt, b_mem_en, b_m0_rvalid} !== 4'b0) begin
      bad++; $display("FAIL lat3_wait got=%b exp=0000", {b_m0_gnt, b_m1_gnt, b_mem_en, b_m0_rvalid});
    end
    nxt; rstn = 1'b0;
    @(negedge clk);
    total++;
    if ({b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_mem_en, b_m0_rdata, b_m1_rdata} !== '0) begin
      bad++; $display("FAIL lat3_in_reset got=%h exp=0", {b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_mem_en, b_m0_rdata, b_m1_rdata});
    end
    nxt; rstn = 1'b1; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h80;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if ({b_m1_gnt, b_m0_rvalid, b_m1_rvalid} !== {c == 0, 1'b0, c == 4}) begin
        bad++; $display("FAIL lat3_cycle_%0d got=%b exp=%b", c, {b_m1_gnt, b_m0_rvalid, b_m1_rvalid}, {c == 0, 1'b0, c == 4});
      end
      if (c == 4) begin
        total++;
        if (b_m1_rdata !== (32'h80 ^ 32'h3333_3333)) begin
          bad++; $display("FAIL lat3_data got=%h exp=%h", b_m1_rdata, 32'h80 ^ 32'h3333_3333);
        end
      end
      nxt; m1_req = 1'b0;
    end
  endtask

  task automatic test_random;
    int free_at = 0, last = 0, pend_k = -1;
    bit pend_m = 1'b0;
    logic [31:0] pend_d = '0, r0 = '0, r1 = '0, ea, ewd;
    logic [3:0] ews;
    bit idle, eg0, eg1, ewe, ev0, ev1;
    rstn = 1'b0; m0_req = 1'b0; m1_req = 1'b0; #1; rstn = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (m0_req ? $urandom_range(0, 15) == 0 : $urandom_range(0, 2) == 0) begin
        m0_req = !m0_req;
        m0_addr = 32'(($urandom_range(0, 15)) * 4);
      end
      if (m1_req ? $urandom_range(0, 15) == 0 : $urandom_range(0, 2) == 0) begin
        m1_req = !m1_req;
        m1_addr = 32'(($urandom_range(0, 15)) * 4);
        m1_we = $urandom_range(0, 1) == 1;
        m1_wdata = $urandom;
        m1_wstrb = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      // a grant is possible only once any earlier read has delivered its pulse;
      // on contention the master that did not win last time gets it
      idle = k >= free_at;
      eg1 = idle && m1_req && !(m0_req && last == 1);
      eg0 = idle && m0_req && !eg1;
      ea  = eg1 ? m1_addr : eg0 ? m0_addr : 32'h0;
      ewe = eg1 && m1_we;
      ewd = eg1 ? m1_wdata : 32'h0;
      ews = eg1 ? m1_wstrb : 4'h0;
      ev0 = pend_k == k && !pend_m;
      ev1 = pend_k == k && pend_m;
      if (ev0) r0 = pend_d;
      if (ev1) r1 = pend_d;
      total++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we} !== {eg0, eg1, ev0, ev1, eg0 || eg1, ewe}) begin
        bad++; $display("FAIL rand_ctrl k=%0d got=%b exp=%b", k, {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we}, {eg0, eg1, ev0, ev1, eg0 || eg1, ewe});
      end
      total++;
      if ({mem_addr, mem_wdata, mem_wstrb, m0_rdata, m1_rdata} !== {ea, ewd, ews, r0, r1}) begin
        bad++; $display("FAIL rand_data k=%0d got=%h exp=%h", k, {mem_addr, mem_wdata, mem_wstrb, m0_rdata, m1_rdata}, {ea, ewd, ews, r0, r1});
      end
      if (eg0 || eg1) begin
        last = eg1 ? 1 : 0;
        if (!ewe) begin
          free_at = k + 2;
          pend_k = k + 2;
          pend_m = eg1;
          pend_d = rd(ea);
        end
      end
      nxt;
      if (eg0) m0_req = 1'b0;
      if (eg1) m1_req = 1'b0;
    end
  endtask

  initial begin
    test_reset;
    test_first_grant;
    test_single_read;
    test_writes;
    test_alternate;
    test_lat3;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
